cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Frame-capture controller between the OV7670 camera pins and the frame-buffer write port. It arms on a software/button request, aligns to a full frame using `vsync`, pairs RGB565 byte halves into RGB332 pixels, generates row-major buffer addresses inside an H_PX × V_PX window, and reports completion and frame-size errors. It replaces free-running address counting with a sequenced single-shot or continuous capture.

## Interface

- `AW`, 15: frame-buffer address width; must satisfy 2^AW ≥ H_PX·V_PX.
- `H_PX`, 160: pixels per line written to the buffer.
- `V_PX`, 120: lines per frame written to the buffer.

- `pclk`  in  1  camera pixel clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  capture request; level-sampled, honoured only in IDLE.
- `cont`  in  1  continuous mode; sampled at each frame end.
- `vsync`  in  1  camera vertical sync; high marks the inter-frame gap.
- `href`  in  1  camera line-valid.
- `px_data`  in  8  camera byte bus.
- `mem_px_addr`  out  AW  buffer write address.
- `mem_px_data`  out  8  RGB332 pixel.
- `px_wr`  out  1  buffer write strobe, one cycle per pixel.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at end of each captured frame.
- `err_size`  out  1  sticky; set when a captured frame's geometry mismatched; cleared by `rst` or accepted `start`.

## Operation

- States: IDLE, WAIT_VS, WAIT_ACT, CAPTURE.
- IDLE: `start`=1 → WAIT_VS, clear `err_size`.
- WAIT_VS: `vsync`=1 → WAIT_ACT (a frame already in progress at arming is skipped).
- WAIT_ACT: `vsync`=0 → CAPTURE; clear row, column, byte-phase, address.
- CAPTURE, while `href`=1: byte phase toggles each cycle. Phase 0 latches byte b0. Phase 1 forms pixel {b0[7:5], b0[2:0], px_data[4:3]}; if col < H_PX and row < V_PX, register it with `px_wr`=1 and current address, then address+1; col+1 always (saturating at 2·H_PX is sufficient).
- `href` falling edge (registered previous `href`=1, now 0): if col ≠ H_PX set line-error flag; row+1; col=0; phase=0. Odd byte count in a line discards the dangling byte.
- `vsync` rising in CAPTURE = frame end: `err_size` set if row ≠ V_PX or line-error flag; pulse `frame_done`; next state WAIT_ACT if `cont`=1, else IDLE.
- Address is accumulated incrementally (no multiplier); never exceeds H_PX·V_PX−1.
- `start` outside IDLE ignored; `cont` dropped mid-frame takes effect at frame end.
- `rst` in any state: IDLE immediately, all counters zero.

## Timing

- Reset values: `mem_px_addr`=0, `mem_px_data`=0, `px_wr`=0, `busy`=0, `frame_done`=0, `err_size`=0.
- Pixel latency: `px_wr` high the cycle after the second byte is sampled; address/data valid in the same cycle as `px_wr`.
- `px_wr` never high on two consecutive cycles.
- `frame_done` high exactly one cycle, the cycle after `vsync` rising is sampled.
- `busy` rises the cycle after `start` is sampled in IDLE; falls with `frame_done` in single-shot.
- `href` and `vsync` changing in the same cycle at frame end: line close (row+1) applied before the row check.

## Structure

- Shared package `cam_pkg`: state encoding constants, default H_PX/V_PX, RGB565→RGB332 bit-select function.
- Sub-module `cam_px_pack`: byte-phase register, b0 latch, RGB332 formation, pixel-valid output; controller owns FSM, counters, address and status.

## Test plan

- Reset, single-shot `start`, model frame 120 lines × 320 bytes → 19200 `px_wr`, last address 19199, one `frame_done`, `err_size`=0, `busy` 0 afterwards.
- Bytes 0xF8,0x1F per pixel → `mem_px_data`=0xE3; 0x07,0xE0 → 0x1C; 0x00,0x18 → 0x03.
- `start` asserted mid-frame (`vsync`=0) → no writes until after next `vsync` high→low; partial frame skipped.
- `cont`=1 for two frames → two `frame_done` pulses, address restarts at 0 each frame; drop `cont` during frame 2 → IDLE after frame 2.
- Frame of 119 lines, or one line of 318 bytes → `err_size`=1, held until next accepted `start`; lines of 340 bytes → extra pixels not written, address max 19199.
- `rst` pulsed mid-CAPTURE → outputs zero next cycle, no `px_wr` until new `start` and full vsync sequence.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 frame-capture path:
// controller states, default geometry and RGB565->RGB332 packing.
package cam_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_VS  = 2'd1,
      ST_WAIT_ACT = 2'd2,
      ST_CAPTURE  = 2'd3
   } cam_state_e;

   localparam int H_PX_DEF = 160;
   localparam int V_PX_DEF = 120;
   localparam int AW_DEF   = 15;

   // hi = first camera byte (R5,G3hi), lo = second byte (G3lo,B5)
   function automatic logic [7:0] rgb565_to_332(
      input logic [7:0] hi,
      input logic [7:0] lo
   );
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

endpackage

// File: rtl/cam_px_pack.sv
// Byte pairing for the camera bus: latches the first byte of each
// pixel and flags a complete RGB332 pixel on the second byte.
module cam_px_pack
   import cam_pkg::*;
(
   input  logic       pclk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       href_i,
   input  logic [7:0] byte_i,
   output logic       vld_o,
   output logic [7:0] pix_o
);

   logic       phase_q, phase_d;
   logic [7:0] b0_q, b0_d;

   // Any gap in href (or leaving capture) drops a dangling first byte.
   always_comb begin
      phase_d = 1'b0;
      b0_d    = b0_q;
      if (en_i && href_i) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            b0_d = byte_i;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         phase_q <= 1'b0;
         b0_q    <= 8'd0;
      end else begin
         phase_q <= phase_d;
         b0_q    <= b0_d;
      end
   end

   assign vld_o = en_i && href_i && phase_q;
   assign pix_o = rgb565_to_332(b0_q, byte_i);

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, aligns to vsync, writes an
// H_PX x V_PX window of RGB332 pixels and flags geometry errors.
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int AW   = AW_DEF,
   parameter int H_PX = H_PX_DEF,
   parameter int V_PX = V_PX_DEF
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          start,
   input  logic          cont,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   output logic [AW-1:0] mem_px_addr,
   output logic [7:0]    mem_px_data,
   output logic          px_wr,
   output logic          busy,
   output logic          frame_done,
   output logic          err_size
);

   localparam int CW = $clog2(2 * H_PX + 1);
   localparam int RW = $clog2(2 * V_PX + 1);

   localparam logic [CW-1:0] COL_H   = CW'(H_PX);
   localparam logic [CW-1:0] COL_MAX = CW'(2 * H_PX);
   localparam logic [RW-1:0] ROW_V   = RW'(V_PX);
   localparam logic [RW-1:0] ROW_MAX = RW'(2 * V_PX);

   cam_state_e    state_q, state_d;
   logic          vsync_q, href_q;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          line_err_q, line_err_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] oaddr_q, oaddr_d;
   logic [7:0]    odata_q, odata_d;

   logic          vs_rise, href_fall;
   logic          cap_en, accept, frame_end;
   logic          pix_vld, in_win, frame_bad;
   logic [7:0]    pix;
   logic [RW-1:0] row_end;

   cam_px_pack u_pack (
      .pclk   (pclk),
      .rst    (rst),
      .en_i   (cap_en),
      .href_i (href),
      .byte_i (px_data),
      .vld_o  (pix_vld),
      .pix_o  (pix)
   );

   assign vs_rise   = vsync && !vsync_q;
   assign href_fall = href_q && !href;

   // A line closing on the frame-end edge still counts toward the row check.
   assign row_end = (href_fall && row_q != ROW_MAX) ?
                    row_q + RW'(1) : row_q;
   assign frame_bad = (row_end != ROW_V) || line_err_q ||
                      (href_fall && col_q != COL_H);
   assign in_win = (col_q < COL_H) && (row_q < ROW_V);

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_WAIT_VS;
         end
         ST_WAIT_VS: begin
            if (vsync) state_d = ST_WAIT_ACT;
         end
         ST_WAIT_ACT: begin
            if (!vsync) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (vs_rise) begin
               state_d = cont ? ST_WAIT_ACT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      cap_en    = (state_q == ST_CAPTURE);
      accept    = (state_q == ST_IDLE) && start;
      frame_end = cap_en && vs_rise;
   end

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      addr_d     = addr_q;
      line_err_d = line_err_q;
      wr_d       = 1'b0;
      oaddr_d    = oaddr_q;
      odata_d    = odata_q;
      done_d     = frame_end;
      err_d      = err_q;

      if (accept) begin
         err_d = 1'b0;
      end else if (frame_end && frame_bad) begin
         err_d = 1'b1;
      end

      if (!cap_en || frame_end) begin
         col_d      = '0;
         row_d      = '0;
         addr_d     = '0;
         line_err_d = 1'b0;
      end else if (href_fall) begin
         row_d = row_end;
         col_d = '0;
         if (col_q != COL_H) begin
            line_err_d = 1'b1;
         end
      end else if (pix_vld) begin
         if (col_q != COL_MAX) begin
            col_d = col_q + CW'(1);
         end
         if (in_win) begin
            wr_d    = 1'b1;
            oaddr_d = addr_q;
            odata_d = pix;
            addr_d  = addr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         addr_q     <= '0;
         line_err_q <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         wr_q       <= 1'b0;
         oaddr_q    <= '0;
         odata_q    <= 8'd0;
      end else begin
         vsync_q    <= vsync;
         href_q     <= href;
         col_q      <= col_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         line_err_q <= line_err_d;
         err_q      <= err_d;
         done_q     <= done_d;
         wr_q       <= wr_d;
         oaddr_q    <= oaddr_d;
         odata_q    <= odata_d;
      end
   end

   assign mem_px_addr = oaddr_q;
   assign mem_px_data = odata_q;
   assign px_wr       = wr_q;
   assign frame_done  = done_q;
   assign err_size    = err_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Randomized camera-frame bench for cam_capture_ctrl with a
// line/pixel level reference model of the expected buffer writes.
module tb_cam_capture_ctrl;

   localparam int H  = 20;
   localparam int V  = 10;
   localparam int AW = 8;

   logic          pclk = 1'b0;
   logic          rst, start, cont, vsync, href;
   logic [7:0]    px_data;
   logic [AW-1:0] mem_px_addr;
   logic [7:0]    mem_px_data;
   logic          px_wr, busy, frame_done, err_size;

   int n_vec = 0;
   int n_err = 0;
   int exp_addr[$];
   int exp_data[$];
   int nw;
   bit exp_err;
   int fd_seen = 0;
   int fd_exp = 0;
   int wr_seen = 0;
   int max_addr = -1;
   bit prev_wr = 1'b0;
   int pat_tbl[6] = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h00, 8'h18};

   always #5 pclk = ~pclk;

   cam_capture_ctrl #(
      .AW   (AW),
      .H_PX (H),
      .V_PX (V)
   ) dut (
      .pclk        (pclk),
      .rst         (rst),
      .start       (start),
      .cont        (cont),
      .vsync       (vsync),
      .href        (href),
      .px_data     (px_data),
      .mem_px_addr (mem_px_addr),
      .mem_px_data (mem_px_data),
      .px_wr       (px_wr),
      .busy        (busy),
      .frame_done  (frame_done),
      .err_size    (err_size)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Red 3 MSBs, green 3 MSBs, blue 2 MSBs of the RGB565 word.
   function automatic int ref332(input int hi, input int lo);
      int word;
      word = hi * 256 + lo;
      return ((word / 8192) % 8) * 32 + ((word / 256) % 8) * 4 +
             ((word / 8) % 4);
   endfunction

   always @(negedge pclk) begin
      if (frame_done === 1'b1) fd_seen++;
      if (px_wr === 1'b1) begin
         wr_seen++;
         chk("wr_spacing", int'(prev_wr), 0);
         if (exp_addr.size() == 0) begin
            chk("spurious_wr", int'(px_wr), 0);
         end else begin
            chk("wr_addr", int'(mem_px_addr), exp_addr.pop_front());
            chk("wr_data", int'(mem_px_data), exp_data.pop_front());
         end
         if (int'(mem_px_addr) > max_addr) max_addr = int'(mem_px_addr);
      end
      prev_wr = (px_wr === 1'b1);
   end

   task automatic cyc(input bit vs, input bit hr, input int d);
      vsync   = vs;
      href    = hr;
      px_data = 8'(d);
      @(negedge pclk);
   endtask

   task automatic line(input int r, input int len, input bit cap,
                       input int mode, input int gap);
      int b0;
      int b;
      b0 = 0;
      for (int i = 0; i < len; i++) begin
         if (mode == 1) b = pat_tbl[((i / 2) % 3) * 2 + (i % 2)];
         else b = int'($urandom_range(0, 255));
         if (i % 2 == 0) begin
            b0 = b;
         end else if (cap && (i / 2) < H && r < V) begin
            exp_addr.push_back(nw);
            exp_data.push_back(ref332(b0, b));
            nw++;
         end
         cyc(1'b0, 1'b1, b);
      end
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 0);
   endtask

   task automatic frame(input int nl, input int len, input int badl,
                        input int badlen, input bit cap, input int mode,
                        input int st_line, input int drop_line);
      bit ferr;
      int l;
      int gap;
      nw = 0;
      wr_seen = 0;
      max_addr = -1;
      ferr = (nl != V);
      cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 0);
      for (int r = 0; r < nl; r++) begin
         l = (r == badl) ? badlen : len;
         if (l / 2 != H) ferr = 1'b1;
         if (r == drop_line) cont = 1'b0;
         if (r == st_line) begin
            start = 1'b1;
            cyc(1'b0, 1'b0, 0);
            start = 1'b0;
            exp_err = 1'b0;
         end
         if (r == nl - 1) gap = int'($urandom_range(0, 2));
         else gap = int'($urandom_range(1, 3));
         line(r, l, cap, mode, gap);
      end
      if (cap) begin
         exp_err = exp_err | ferr;
         fd_exp++;
      end
   endtask

   task automatic vs_pulse(input bit fd, input bit bz);
      cyc(1'b1, 1'b0, 0);
      chk("frame_done", int'(frame_done), int'(fd));
      chk("busy_at_vs", int'(busy), int'(bz));
      chk("err_size", int'(err_size), int'(exp_err));
      cyc(1'b1, 1'b0, 0);
      chk("done_width", int'(frame_done), 0);
      cyc(1'b1, 1'b0, 0);
      cyc(1'b1, 1'b0, 0);
   endtask

   task automatic arm();
      start = 1'b1;
      cyc(1'b1, 1'b0, 0);
      start = 1'b0;
      exp_err = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      chk("err_clear", int'(err_size), int'(exp_err));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, int'(mem_px_addr), 0);
      chk({tag, "_data"}, int'(mem_px_data), 0);
      chk({tag, "_wr"}, int'(px_wr), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(frame_done), 0);
      chk({tag, "_err"}, int'(err_size), 0);
   endtask

   initial begin
      int lens[4];
      int nl, len, badl, badlen, sel;
      lens = '{2 * H, 2 * H - 2, 2 * H + 1, 2 * H + 4};
      rst = 1'b1; start = 1'b0; cont = 1'b0;
      vsync = 1'b0; href = 1'b0; px_data = 8'd0;
      exp_err = 1'b0;
      @(negedge pclk);
      cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 0);
      chk_zero("reset");
      rst = 1'b0;
      cyc(1'b0, 1'b0, 0);

      // single shot, colour-bar byte pairs
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V, 2 * H, -1, 0, 1'b1, 1, -1, -1);
      vs_pulse(1'b1, 1'b0);
      chk("single_pending", exp_addr.size(), 0);
      chk("single_writes", wr_seen, H * V);
      chk("single_last_addr", max_addr, H * V - 1);

      // start during an active frame skips that frame
      vs_pulse(1'b0, 1'b0);
      frame(V, 2 * H, -1, 0, 1'b0, 0, 4, -1);
      chk("skip_writes", wr_seen, 0);
      vs_pulse(1'b0, 1'b1);
      frame(V, 2 * H, -1, 0, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b0);
      chk("skip_pending", exp_addr.size(), 0);

      // continuous, cont dropped during the second frame
      cont = 1'b1;
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V, 2 * H, -1, 0, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b1);
      chk("cont1_last_addr", max_addr, H * V - 1);
      frame(V, 2 * H, -1, 0, 1'b1, 0, -1, 3);
      vs_pulse(1'b1, 1'b0);
      chk("cont2_last_addr", max_addr, H * V - 1);
      frame(V, 2 * H, -1, 0, 1'b0, 0, -1, -1);
      vs_pulse(1'b0, 1'b0);
      chk("cont_idle_writes", wr_seen, 0);

      // geometry errors and their stickiness
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V - 1, 2 * H, -1, 0, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 0);
      chk("err_sticky", int'(err_size), int'(exp_err));
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V, 2 * H, 5, 2 * H - 2, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b0);
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V, 2 * H + 4, -1, 0, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b0);
      chk("long_writes", wr_seen, H * V);
      chk("long_last_addr", max_addr, H * V - 1);
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V, 2 * H, 2, 2 * H + 1, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b0);
      arm();
      vs_pulse(1'b0, 1'b1);
      frame(V + 1, 2 * H, -1, 0, 1'b1, 0, -1, -1);
      vs_pulse(1'b1, 1'b0);
      chk("extra_rows_writes", wr_seen, H * V);

      // reset in the middle of a capture
      arm();
      vs_pulse(1'b0, 1'b1);
      nw = 0;
      cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 0);
      for (int r = 0; r < 4; r++) line(r, 2 * H, 1'b1, 0, 2);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 0);
      chk_zero("mid_rst");
      rst = 1'b0;
      exp_err = 1'b0;
      wr_seen = 0;
      for (int r = 4; r < V; r++) line(r, 2 * H, 1'b0, 0, 2);
      vs_pulse(1'b0, 1'b0);
      frame(V, 2 * H, -1, 0, 1'b0, 0, -1, -1);
      vs_pulse(1'b0, 1'b0);
      chk("post_rst_writes", wr_seen, 0);

      // random geometry and data
      for (int k = 0; k < 8; k++) begin
         sel = int'($urandom_range(0, 3));
         nl = (sel == 0) ? V - 1 : (sel == 1) ? V + 1 : V;
         len = lens[$urandom_range(0, 3)];
         badl = int'($urandom_range(0, V));
         badlen = lens[$urandom_range(0, 3)];
         arm();
         vs_pulse(1'b0, 1'b1);
         frame(nl, len, badl, badlen, 1'b1, 0, -1, -1);
         vs_pulse(1'b1, 1'b0);
         chk("rand_pending", exp_addr.size(), 0);
      end

      chk("frame_done_total", fd_seen, fd_exp);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
